// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM request-port arbiter: FSM states, burst owner
// and the width of the burst-length / beat-counter fields.
package sdram_arb_pkg;

  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT_ACK,
    XFER
  } state_t;

  typedef enum logic {
    OWN_R,
    OWN_W
  } owner_t;

endpackage

// File: rtl/sdram_arb_sel.sv
// Priority select between the video read port and the writer, with a
// saturating read-streak counter that hands the port to W after a run of R bursts.
module sdram_arb_sel
  import sdram_arb_pkg::*;
#(
  parameter int MAX_RD_STREAK = 4,
  parameter int STREAK_W      = $clog2(MAX_RD_STREAK + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                r_req,
  input  logic                w_req,
  input  logic                idle,
  input  logic                grant_en,
  output owner_t              sel,
  output logic [STREAK_W-1:0] streak
);

  logic [STREAK_W-1:0] streak_reg;
  logic                at_max;

  assign at_max = (streak_reg == STREAK_W'(MAX_RD_STREAK));
  assign sel    = (w_req && (!r_req || at_max)) ? OWN_W : OWN_R;
  assign streak = streak_reg;

  // The streak only grows while W is actually waiting; an idle port with no
  // W pending forgets any earlier run of reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak_reg <= '0;
    end else if (grant_en && w_req && (sel == OWN_W)) begin
      streak_reg <= '0;
    end else if (idle && !w_req) begin
      streak_reg <= '0;
    end else if (grant_en && r_req && !at_max) begin
      streak_reg <= streak_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller request port between the frame-buffer reader (R)
// and the pixel writer (W), one burst at a time.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W        = 21,
  parameter int DATA_W        = 16,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sdrc_init_done,
  input  logic              sdrc_busy_n,
  input  logic              sdrc_wrd_ack,
  input  logic              sdrc_rd_valid,
  input  logic [DATA_W-1:0] sdrc_rdata,
  output logic              sdrc_wr_n,
  output logic              sdrc_rd_n,
  output logic [ADDR_W-1:0] sdrc_addr,
  output logic [LEN_W-1:0]  sdrc_data_len,
  output logic [DATA_W-1:0] sdrc_wdata,
  output logic [1:0]        sdrc_dqm,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [LEN_W-1:0]  r_len,
  output logic              r_gnt,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_data,
  output logic              r_done,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [LEN_W-1:0]  w_len,
  input  logic [1:0]        w_dqm,
  output logic              w_gnt,
  output logic              w_beat,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_done
);

  localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);

  state_t              state_reg;
  owner_t              owner_reg;
  logic [LEN_W-1:0]    cnt_reg;
  logic                beats_done_reg;
  logic                wr_n_reg;
  logic                rd_n_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [1:0]          dqm_reg;
  logic                r_done_reg;
  logic                w_done_reg;

  owner_t              sel;
  logic [STREAK_W-1:0] streak_unused;
  logic                idle;
  logic                grant_en;
  logic                grant;
  logic                in_xfer;
  logic                beat;

  sdram_arb_sel #(
    .MAX_RD_STREAK (MAX_RD_STREAK),
    .STREAK_W      (STREAK_W)
  ) u_sel (
    .clk      (clk),
    .resetn   (resetn),
    .r_req    (r_req),
    .w_req    (w_req),
    .idle     (idle),
    .grant_en (grant_en),
    .sel      (sel),
    .streak   (streak_unused)
  );

  // No grant while a done pulse is out, so the next burst starts after it.
  assign idle     = (state_reg == IDLE);
  assign grant_en = resetn && idle && sdrc_init_done && sdrc_busy_n &&
                    !r_done_reg && !w_done_reg;
  assign grant    = grant_en && (r_req || w_req);
  assign r_gnt    = grant && (sel == OWN_R);
  assign w_gnt    = grant && (sel == OWN_W);

  assign in_xfer    = (state_reg == XFER) && !beats_done_reg;
  assign w_beat     = in_xfer && (owner_reg == OWN_W);
  assign r_valid    = in_xfer && (owner_reg == OWN_R) && sdrc_rd_valid;
  assign beat       = w_beat || r_valid;
  assign r_data     = r_valid ? sdrc_rdata : '0;
  assign sdrc_wdata = ((state_reg == XFER) && (owner_reg == OWN_W)) ? w_data : '0;

  assign sdrc_wr_n     = wr_n_reg;
  assign sdrc_rd_n     = rd_n_reg;
  assign sdrc_addr     = addr_reg;
  assign sdrc_data_len = len_reg;
  assign sdrc_dqm      = dqm_reg;
  assign r_done        = r_done_reg;
  assign w_done        = w_done_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_R;
      cnt_reg        <= '0;
      beats_done_reg <= 1'b0;
      wr_n_reg       <= 1'b1;
      rd_n_reg       <= 1'b1;
      addr_reg       <= '0;
      len_reg        <= '0;
      dqm_reg        <= '0;
      r_done_reg     <= 1'b0;
      w_done_reg     <= 1'b0;
    end else begin
      r_done_reg <= 1'b0;
      w_done_reg <= 1'b0;
      wr_n_reg   <= 1'b1;
      rd_n_reg   <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (grant) begin
            owner_reg <= sel;
            state_reg <= CMD;
            if (sel == OWN_W) begin
              addr_reg <= w_addr;
              len_reg  <= w_len;
              dqm_reg  <= w_dqm;
              wr_n_reg <= 1'b0;
            end else begin
              addr_reg <= r_addr;
              len_reg  <= r_len;
              dqm_reg  <= '0;
              rd_n_reg <= 1'b0;
            end
          end
        end
        CMD: begin
          state_reg <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (sdrc_wrd_ack) begin
            cnt_reg        <= len_reg;
            beats_done_reg <= 1'b0;
            state_reg      <= XFER;
          end
        end
        XFER: begin
          // Counts down from len, so len = 255 yields 256 beats without wrapping.
          if (beat) begin
            if (cnt_reg == '0) begin
              beats_done_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          if (beats_done_reg && sdrc_busy_n) begin
            state_reg <= IDLE;
            if (owner_reg == OWN_R) begin
              r_done_reg <= 1'b1;
            end else begin
              w_done_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
